// File: rtl/cache_pkg.sv
// Shared data-cache types: per-array enables, status packet, arbiter owner and FSM state.
package cache_pkg;

    typedef struct packed {
        logic data;
        logic tag;
        logic dirty;
        logic valid;
    } data_enable_t;

    typedef struct packed {
        logic       valid;
        logic       dirty;
        logic [1:0] way;
    } status_packet_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        STORE
    } arb_owner_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_OWN,
        STORE_OWN
    } arb_state_t;

endpackage

// File: rtl/arbiter_starvation_counter.sv
// Counts cycles the store controller waits for the cache port; saturates at LIMIT.
module arbiter_starvation_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           request_i,
    input  logic                           grant_i,
    output logic                           starved_o,
    output logic [$clog2(LIMIT+1)-1:0]     count_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || grant_i) begin
            count_q <= '0;
        end else if (request_i && (count_q != W'(LIMIT))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign starved_o = (count_q == W'(LIMIT));
    assign count_o   = count_q;

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache port between load and store controllers.
// Define DCACHE_ARB_ANTI_STARVATION_EN to force a store grant after STARVE_LIMIT wait cycles.
module dcache_port_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                ld_request_i,
    input  logic                                ld_lock_i,
    input  logic [31:0]                         ld_address_i,
    input  logic [31:0]                         ld_data_i,
    input  data_enable_t                        ld_read_i,
    input  data_enable_t                        ld_write_i,
    input  status_packet_t                      ld_status_i,
    input  logic                                st_request_i,
    input  logic                                st_lock_i,
    input  logic [31:0]                         st_address_i,
    input  logic [31:0]                         st_data_i,
    input  data_enable_t                        st_read_i,
    input  data_enable_t                        st_write_i,
    input  status_packet_t                      st_status_i,
    output logic                                ld_grant_o,
    output logic                                st_grant_o,
    output logic [31:0]                         cache_address_o,
    output logic [31:0]                         cache_data_o,
    output data_enable_t                        cache_read_o,
    output data_enable_t                        cache_write_o,
    output status_packet_t                      cache_status_o,
    output logic                                ld_rvalid_o,
    output logic                                st_rvalid_o,
    output arb_state_t                          dbg_state_o,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]   dbg_wait_count_o
);

    arb_state_t state_q;
    arb_owner_t owner;
    logic       starved;
    logic       ld_rvalid_q;
    logic       st_rvalid_q;

`ifdef DCACHE_ARB_ANTI_STARVATION_EN
    arbiter_starvation_counter #(
        .LIMIT     (STARVE_LIMIT)
    ) u_starve (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .request_i (st_request_i),
        .grant_i   (st_grant_o),
        .starved_o (starved),
        .count_o   (dbg_wait_count_o)
    );
`else
    assign starved          = 1'b0;
    assign dbg_wait_count_o = '0;
`endif

    // Grant is combinational in IDLE so a requester is served in its first request cycle.
    always_comb begin
        owner = NONE;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (st_request_i && (starved || !ld_request_i)) begin
                        owner = STORE;
                    end else if (ld_request_i) begin
                        owner = LOAD;
                    end
                end
                LOAD_OWN:  owner = LOAD;
                STORE_OWN: owner = STORE;
                default:   owner = NONE;
            endcase
        end
    end

    assign ld_grant_o = (owner == LOAD);
    assign st_grant_o = (owner == STORE);

    always_comb begin
        cache_address_o = '0;
        cache_data_o    = '0;
        cache_read_o    = '0;
        cache_write_o   = '0;
        cache_status_o  = '0;
        if (ld_grant_o) begin
            cache_address_o = ld_address_i;
            cache_data_o    = ld_data_i;
            cache_read_o    = ld_read_i;
            cache_write_o   = ld_write_i;
            cache_status_o  = ld_status_i;
        end else if (st_grant_o) begin
            cache_address_o = st_address_i;
            cache_data_o    = st_data_i;
            cache_read_o    = st_read_i;
            cache_write_o   = st_write_i;
            cache_status_o  = st_status_i;
        end
    end

    // Ownership is held while the owner's lock is high; the release cycle stays granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ld_rvalid_q <= 1'b0;
            st_rvalid_q <= 1'b0;
        end else begin
            ld_rvalid_q <= ld_grant_o && (ld_read_i != '0);
            st_rvalid_q <= st_grant_o && (st_read_i != '0);
            case (state_q)
                IDLE: begin
                    if (owner == LOAD && ld_lock_i) begin
                        state_q <= LOAD_OWN;
                    end else if (owner == STORE && st_lock_i) begin
                        state_q <= STORE_OWN;
                    end
                end
                LOAD_OWN: begin
                    if (!ld_lock_i) state_q <= IDLE;
                end
                STORE_OWN: begin
                    if (!st_lock_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ld_rvalid_o = ld_rvalid_q;
    assign st_rvalid_o = st_rvalid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter; expectations follow the macro DCACHE_ARB_ANTI_STARVATION_EN.
module tb_dcache_port_arbiter;
    import cache_pkg::*;

`ifdef DCACHE_ARB_ANTI_STARVATION_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_i;
    logic           ld_request_i, ld_lock_i, st_request_i, st_lock_i;
    logic [31:0]    ld_address_i, ld_data_i, st_address_i, st_data_i;
    data_enable_t   ld_read_i, ld_write_i, st_read_i, st_write_i;
    status_packet_t ld_status_i, st_status_i;
    logic           ld_grant_o, st_grant_o, ld_rvalid_o, st_rvalid_o;
    logic [31:0]    cache_address_o, cache_data_o;
    data_enable_t   cache_read_o, cache_write_o;
    status_packet_t cache_status_o;
    arb_state_t     dbg_state_o;
    logic [3:0]     dbg_wait_count_o;

    int checks = 0;
    int errors = 0;

    dcache_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ld_request_i(ld_request_i), .ld_lock_i(ld_lock_i), .ld_address_i(ld_address_i),
        .ld_data_i(ld_data_i), .ld_read_i(ld_read_i), .ld_write_i(ld_write_i), .ld_status_i(ld_status_i),
        .st_request_i(st_request_i), .st_lock_i(st_lock_i), .st_address_i(st_address_i),
        .st_data_i(st_data_i), .st_read_i(st_read_i), .st_write_i(st_write_i), .st_status_i(st_status_i),
        .ld_grant_o(ld_grant_o), .st_grant_o(st_grant_o),
        .cache_address_o(cache_address_o), .cache_data_o(cache_data_o), .cache_read_o(cache_read_o),
        .cache_write_o(cache_write_o), .cache_status_o(cache_status_o),
        .ld_rvalid_o(ld_rvalid_o), .st_rvalid_o(st_rvalid_o),
        .dbg_state_o(dbg_state_o), .dbg_wait_count_o(dbg_wait_count_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ld_request_i = 0; ld_lock_i = 0; ld_address_i = '0; ld_data_i = '0;
        ld_read_i = '0; ld_write_i = '0; ld_status_i = '0;
        st_request_i = 0; st_lock_i = 0; st_address_i = '0; st_data_i = '0;
        st_read_i = '0; st_write_i = '0; st_status_i = '0;
    endtask

    // Leaves the bench at the start of the first post-reset cycle with all inputs idle.
    task automatic do_reset();
        cyc();
        rst_i = 1;
        clear_inputs();
        cyc();
        rst_i = 0;
    endtask

    task automatic test_reset();
        cyc();
        rst_i = 1;
        ld_request_i = 1; st_request_i = 1; ld_read_i = 4'hf; ld_address_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b0 || st_grant_o !== 1'b0) begin errors++; $display("FAIL reset_grants: got %b%b expected 00", ld_grant_o, st_grant_o); end
        checks++; if (cache_address_o !== 32'h0 || cache_read_o !== 4'h0) begin errors++; $display("FAIL reset_cache_out: got %h/%h expected 0/0", cache_address_o, cache_read_o); end
        cyc();
        @(negedge clk);
        checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, IDLE); end
        checks++; if (ld_rvalid_o !== 1'b0 || st_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", ld_rvalid_o, st_rvalid_o); end
        checks++; if (dbg_wait_count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dbg_wait_count_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ld_request_i = 1; st_request_i = 1;
        ld_address_i = 32'hAAAA_0010; ld_data_i = 32'hDEAD_BEEF; ld_write_i = 4'b0101; ld_status_i = 4'b1010;
        st_address_i = 32'hBBBB_0020; st_data_i = 32'h0BAD_F00D; st_write_i = 4'b1000; st_status_i = 4'b0111;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b1 || st_grant_o !== 1'b0) begin errors++; $display("FAIL sim_c0_grants: got %b%b expected 10", ld_grant_o, st_grant_o); end
        checks++; if (cache_address_o !== 32'hAAAA_0010 || cache_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_c0_mux: got %h/%h expected aaaa0010/deadbeef", cache_address_o, cache_data_o); end
        checks++; if (cache_write_o !== 4'b0101 || cache_status_o !== 4'b1010) begin errors++; $display("FAIL sim_c0_ctl: got %h/%h expected 5/a", cache_write_o, cache_status_o); end
        cyc();
        ld_request_i = 0;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b0 || st_grant_o !== 1'b1) begin errors++; $display("FAIL sim_c1_grants: got %b%b expected 01", ld_grant_o, st_grant_o); end
        checks++; if (cache_address_o !== 32'hBBBB_0020 || cache_write_o !== 4'b1000 || cache_status_o !== 4'b0111) begin errors++; $display("FAIL sim_c1_mux: got %h/%h/%h expected bbbb0020/8/7", cache_address_o, cache_write_o, cache_status_o); end
        cyc();
        st_request_i = 0;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b0 || st_grant_o !== 1'b0) begin errors++; $display("FAIL sim_c2_grants: got %b%b expected 00", ld_grant_o, st_grant_o); end
        checks++; if (cache_address_o !== 32'h0 || cache_data_o !== 32'h0 || cache_write_o !== 4'h0) begin errors++; $display("FAIL sim_c2_zero: got %h/%h/%h expected 0/0/0", cache_address_o, cache_data_o, cache_write_o); end
    endtask

    task automatic test_lock();
        do_reset();
        st_request_i = 1;
        for (int c = 0; c < 6; c++) begin
            ld_request_i = (c < 4); ld_lock_i = (c < 4);
            @(negedge clk);
            checks++; if (st_grant_o !== (c == 5)) begin errors++; $display("FAIL lock_st_grant c%0d: got %b expected %b", c, st_grant_o, (c == 5)); end
            checks++; if (ld_grant_o !== (c < 5)) begin errors++; $display("FAIL lock_ld_grant c%0d: got %b expected %b", c, ld_grant_o, (c < 5)); end
            if (c == 2) begin
                checks++; if (dbg_state_o !== LOAD_OWN) begin errors++; $display("FAIL lock_state: got %0d expected %0d", dbg_state_o, LOAD_OWN); end
            end
            cyc();
        end
    endtask

    task automatic test_rvalid();
        do_reset();
        for (int c = 0; c < 5; c++) cyc();
        st_request_i = 1; st_read_i = 4'b1000; st_address_i = 32'h0000_1000;
        @(negedge clk);
        checks++; if (st_grant_o !== 1'b1 || cache_read_o !== 4'b1000 || cache_address_o !== 32'h0000_1000) begin errors++; $display("FAIL rv_c5: got %b/%h/%h expected 1/8/00001000", st_grant_o, cache_read_o, cache_address_o); end
        checks++; if (st_rvalid_o !== 1'b0) begin errors++; $display("FAIL rv_c5_early: got %b expected 0", st_rvalid_o); end
        cyc();
        st_request_i = 0; st_read_i = '0; ld_request_i = 1; ld_read_i = 4'b0100;
        @(negedge clk);
        checks++; if (st_rvalid_o !== 1'b1 || ld_rvalid_o !== 1'b0) begin errors++; $display("FAIL rv_c6: got st=%b ld=%b expected st=1 ld=0", st_rvalid_o, ld_rvalid_o); end
        checks++; if (ld_grant_o !== 1'b1) begin errors++; $display("FAIL rv_c6_ld_grant: got %b expected 1", ld_grant_o); end
        cyc();
        ld_request_i = 0; ld_read_i = '0;
        @(negedge clk);
        checks++; if (st_rvalid_o !== 1'b0 || ld_rvalid_o !== 1'b1) begin errors++; $display("FAIL rv_c7: got st=%b ld=%b expected st=0 ld=1", st_rvalid_o, ld_rvalid_o); end
        cyc();
        @(negedge clk);
        checks++; if (st_rvalid_o !== 1'b0 || ld_rvalid_o !== 1'b0) begin errors++; $display("FAIL rv_c8: got st=%b ld=%b expected 00", st_rvalid_o, ld_rvalid_o); end
    endtask

    task automatic test_starvation();
        logic       exp_st;
        logic [3:0] exp_cnt;
        do_reset();
        ld_request_i = 1; st_request_i = 1;
        for (int c = 0; c < 12; c++) begin
            exp_st  = ANTI && (c == 8);
            exp_cnt = !ANTI ? 4'd0 : (c <= 8 ? 4'(c) : 4'(c - 9));
            @(negedge clk);
            checks++; if (st_grant_o !== exp_st || ld_grant_o !== !exp_st) begin errors++; $display("FAIL starve_grant c%0d: got %b%b expected %b%b", c, ld_grant_o, st_grant_o, !exp_st, exp_st); end
            checks++; if (dbg_wait_count_o !== exp_cnt) begin errors++; $display("FAIL starve_count c%0d: got %0d expected %0d", c, dbg_wait_count_o, exp_cnt); end
            cyc();
        end
    endtask

    task automatic test_lock_ignored();
        do_reset();
        ld_lock_i = 1; st_lock_i = 1;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b0 || st_grant_o !== 1'b0) begin errors++; $display("FAIL lockign_grants: got %b%b expected 00", ld_grant_o, st_grant_o); end
        cyc();
        @(negedge clk);
        checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL lockign_state: got %0d expected %0d", dbg_state_o, IDLE); end
        st_request_i = 1; ld_lock_i = 0;
        @(negedge clk);
        checks++; if (st_grant_o !== 1'b1) begin errors++; $display("FAIL lockign_st_grant: got %b expected 1", st_grant_o); end
        cyc();
        st_request_i = 0; st_lock_i = 0; ld_request_i = 1;
        @(negedge clk);
        checks++; if (dbg_state_o !== STORE_OWN || st_grant_o !== 1'b1 || ld_grant_o !== 1'b0) begin errors++; $display("FAIL lockign_release: got state=%0d grants=%b%b expected %0d/01", dbg_state_o, ld_grant_o, st_grant_o, STORE_OWN); end
        cyc();
        @(negedge clk);
        checks++; if (dbg_state_o !== IDLE || ld_grant_o !== 1'b1) begin errors++; $display("FAIL lockign_after: got state=%0d ld=%b expected %0d/1", dbg_state_o, ld_grant_o, IDLE); end
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        st_request_i = 1; st_lock_i = 1; st_address_i = 32'hC0DE_0040;
        @(negedge clk);
        checks++; if (st_grant_o !== 1'b1) begin errors++; $display("FAIL rstown_c0: got %b expected 1", st_grant_o); end
        cyc();
        st_request_i = 0; ld_request_i = 1; ld_address_i = 32'h0000_0080;
        @(negedge clk);
        checks++; if (dbg_state_o !== STORE_OWN || st_grant_o !== 1'b1 || ld_grant_o !== 1'b0) begin errors++; $display("FAIL rstown_c1: got state=%0d grants=%b%b expected %0d/01", dbg_state_o, ld_grant_o, st_grant_o, STORE_OWN); end
        cyc();
        rst_i = 1;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b0 || st_grant_o !== 1'b0 || cache_address_o !== 32'h0) begin errors++; $display("FAIL rstown_c2: got grants=%b%b addr=%h expected 00/0", ld_grant_o, st_grant_o, cache_address_o); end
        cyc();
        rst_i = 0; st_lock_i = 0;
        @(negedge clk);
        checks++; if (ld_grant_o !== 1'b1 || cache_address_o !== 32'h0000_0080 || dbg_state_o !== IDLE) begin errors++; $display("FAIL rstown_c3: got ld=%b addr=%h state=%0d expected 1/00000080/%0d", ld_grant_o, cache_address_o, dbg_state_o, IDLE); end
    endtask

    initial begin
        rst_i = 1;
        clear_inputs();
        test_reset();
        test_simultaneous();
        test_lock();
        test_rvalid();
        test_starvation();
        test_lock_ignored();
        test_reset_mid_own();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
